// File: rtl/cpu_pkg.sv
// Shared CPU definitions: the opcode map used by fetch and Control, the fetch
// FSM state encoding and the default address/instruction widths.
package cpu_pkg;

  localparam int unsigned AW_DEF = 8;
  localparam int unsigned IW_DEF = 16;
  localparam int unsigned OPW    = 4;

  localparam logic [OPW-1:0] OP_LOAD  = 4'd0;
  localparam logic [OPW-1:0] OP_ADDI  = 4'd1;
  localparam logic [OPW-1:0] OP_STORE = 4'd2;
  localparam logic [OPW-1:0] OP_BEQZ  = 4'd3;
  localparam logic [OPW-1:0] OP_HALT  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read port: REQ/ACK handshake with address and data.
//   req  : read request, held until ack
//   addr : read address
//   ack  : one-cycle strobe, data valid this cycle
//   data : instruction word
// master = fetch stage, slave = instruction memory.
interface instr_fetch_if
  import cpu_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned IW = IW_DEF
);

  logic          req;
  logic [AW-1:0] addr;
  logic          ack;
  logic [IW-1:0] data;

  modport master (output req, output addr, input ack, input data);
  modport slave  (input req, input addr, output ack, output data);

endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC: PC+1, or PC+1+sign-extended offset when a branch is
// taken. Arithmetic wraps modulo 2^AW.
//   i_pc          : current program counter
//   i_offset      : two's-complement branch offset field
//   i_take_branch : select branch-relative target
//   o_pc_next_c   : next program counter (combinational)
module pc_next_calc #(
  parameter int unsigned AW   = 8,
  parameter int unsigned OFFW = 6
) (
  input  logic [AW-1:0]   i_pc,
  input  logic [OFFW-1:0] i_offset,
  input  logic            i_take_branch,
  output logic [AW-1:0]   o_pc_next_c
);

  logic [AW-1:0] w_off_ext;
  logic [AW-1:0] w_pc_inc;

  // Size cast of a signed operand sign-extends the offset to AW bits.
  assign w_off_ext   = AW'($signed(i_offset));
  assign w_pc_inc    = i_pc + AW'(1);
  assign o_pc_next_c = i_take_branch ? (w_pc_inc + w_off_ext) : w_pc_inc;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads instruction memory over a REQ/ACK port,
// holds the fetched word in the instruction register and applies sequential,
// branch or halt updates once the instruction has executed.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   imem             : instruction-memory master port
//   o_instr          : instruction register
//   o_opcode_c       : opcode field of o_instr (combinational)
//   o_instr_valid_c  : high in ISSUE (combinational)
//   i_stall          : hold ISSUE while the datapath is busy
//   i_branch, i_zero : branch request and ALU zero flag, sampled in ISSUE
//   i_halt           : halt request from Control, sampled in ISSUE
//   o_pc             : program counter
//   o_halted         : sticky halt indicator
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned AW          = AW_DEF,
  parameter int unsigned IW          = IW_DEF,
  parameter int unsigned OFFW        = 6,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned HALT_OPCODE = 15
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  instr_fetch_if.master  imem,
  output logic [IW-1:0]  o_instr,
  output logic [OPW-1:0] o_opcode_c,
  output logic           o_instr_valid_c,
  input  logic           i_stall,
  input  logic           i_branch,
  input  logic           i_zero,
  input  logic           i_halt,
  output logic [AW-1:0]  o_pc,
  output logic           o_halted
);

  fetch_state_e  r_state;
  logic          r_req;
  logic [AW-1:0] r_pc;
  logic [IW-1:0] r_instr;
  logic          r_halted;

  logic [AW-1:0] w_pc_next;
  logic          w_take_branch;
  logic          w_halt_now;

  assign w_take_branch = i_branch & i_zero;
  assign w_halt_now    = i_halt | (o_opcode_c == OPW'(HALT_OPCODE));

  pc_next_calc #(
    .AW   (AW),
    .OFFW (OFFW)
  ) u_pc_next (
    .i_pc          (r_pc),
    .i_offset      (r_instr[OFFW-1:0]),
    .i_take_branch (w_take_branch),
    .o_pc_next_c   (w_pc_next)
  );

  // Fetch FSM; REQ is registered so it is high exactly while in FETCH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_req    <= 1'b0;
      r_pc     <= AW'(RESET_PC);
      r_instr  <= '0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_req   <= 1'b1;
          r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (imem.ack) begin
            r_instr <= imem.data;
            r_req   <= 1'b0;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Priority: stall > halt > branch/sequential.
          if (!i_stall) begin
            if (w_halt_now) begin
              r_halted <= 1'b1;
              r_state  <= ST_HALTED;
            end else begin
              r_pc    <= w_pc_next;
              r_req   <= 1'b1;
              r_state <= ST_FETCH;
            end
          end
        end
        ST_HALTED: begin
          r_req <= 1'b0;
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem.req        = r_req;
  assign imem.addr       = r_pc;
  assign o_instr         = r_instr;
  assign o_opcode_c      = r_instr[IW-1 -: OPW];
  assign o_instr_valid_c = (r_state == ST_ISSUE);
  assign o_pc            = r_pc;
  assign o_halted        = r_halted;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: acts as instruction memory and Control, keeps a
// scoreboard of expected fetch addresses and issued instructions.
module tb_instr_fetch;
  import cpu_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned IW = 16;

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] word;
  } issue_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall = 1'b0;
  logic          branch = 1'b0;
  logic          zero = 1'b0;
  logic          halt = 1'b0;
  logic [IW-1:0] instr;
  logic [3:0]    opcode;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic          halted;

  logic [AW-1:0] q_addr[$];
  issue_t        q_issue[$];
  int            n_checks = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  instr_fetch_if #(.AW(AW), .IW(IW)) imem_if ();

  instr_fetch #(
    .AW(AW), .IW(IW), .OFFW(6), .RESET_PC(0), .HALT_OPCODE(15)
  ) u_dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .imem            (imem_if.master),
    .o_instr         (instr),
    .o_opcode_c      (opcode),
    .o_instr_valid_c (instr_valid),
    .i_stall         (stall),
    .i_branch        (branch),
    .i_zero          (zero),
    .i_halt          (halt),
    .o_pc            (pc),
    .o_halted        (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Asynchronous reset between clock edges; the fetch then restarts at 0.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req",    32'(imem_if.req), 32'd0);
    chk("rst_pc",     32'(pc),          32'd0);
    chk("rst_instr",  32'(instr),       32'd0);
    chk("rst_valid",  32'(instr_valid), 32'd0);
    chk("rst_halted", 32'(halted),      32'd0);
    q_addr.delete();
    q_issue.delete();
    q_addr.push_back(8'd0);
    @(negedge clk);
    // Release with a stray ACK in the IDLE cycle: it must not load INSTR.
    rst_n = 1'b1;
    imem_if.ack = 1'b1;
    imem_if.data = 16'hBEEF;
    @(negedge clk);
    imem_if.ack = 1'b0;
    chk("late_ack_ignored", 32'(instr), 32'd0);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (imem_if.req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("req_timeout", 32'(imem_if.req), 32'd1);
  endtask

  // Serve one read after lat wait cycles; pushes the expected issue record.
  task automatic fetch(input logic [IW-1:0] word, input int lat);
    bit ok;
    logic [AW-1:0] ea;
    wait_req(ok);
    if (!ok) return;
    if (q_addr.size() != 0) ea = q_addr.pop_front();
    else ea = 'x;
    chk("imem_addr", 32'(imem_if.addr), 32'(ea));
    for (int i = 0; i < lat; i++) begin
      chk("req_held",    32'(imem_if.req),  32'd1);
      chk("addr_stable", 32'(imem_if.addr), 32'(ea));
      @(negedge clk);
    end
    imem_if.ack = 1'b1;
    imem_if.data = word;
    q_issue.push_back('{ea, word});
    @(negedge clk);
    imem_if.ack = 1'b0;
    imem_if.data = 16'(($urandom));
    chk("req_drop",   32'(imem_if.req), 32'd0);
    chk("valid_rise", 32'(instr_valid), 32'd1);
  endtask

  // Execute the issued instruction; exp_next is the required next fetch address.
  task automatic issue(input int n_stall, input bit br, input bit zr, input bit hl,
                       input bit spurious, input logic [AW-1:0] exp_next);
    issue_t e;
    if (q_issue.size() == 0) begin
      chk("issue_q_empty", 32'(q_issue.size()), 32'd1);
      return;
    end
    e = q_issue.pop_front();
    chk("instr",  32'(instr),  32'(e.word));
    chk("opcode", 32'(opcode), 32'(e.word[15:12]));
    chk("pc",     32'(pc),     32'(e.pc));
    for (int i = 0; i < n_stall; i++) begin
      stall = 1'b1;
      branch = 1'b1;
      zero = (i % 2 == 0);
      if (spurious && i == 0) begin
        imem_if.ack = 1'b1;
        imem_if.data = 16'h3FFF;
      end
      @(negedge clk);
      imem_if.ack = 1'b0;
      chk("stall_pc",    32'(pc),          32'(e.pc));
      chk("stall_instr", 32'(instr),       32'(e.word));
      chk("stall_valid", 32'(instr_valid), 32'd1);
    end
    stall = 1'b0;
    branch = br;
    zero = zr;
    halt = hl;
    @(negedge clk);
    branch = 1'b0;
    zero = 1'b0;
    halt = 1'b0;
    if (hl || e.word[15:12] == 4'hF) begin
      chk("halted",      32'(halted),      32'd1);
      chk("halt_pc",     32'(pc),          32'(e.pc));
      chk("halt_req",    32'(imem_if.req), 32'd0);
      chk("halt_valid",  32'(instr_valid), 32'd0);
    end else begin
      chk("valid_drop", 32'(instr_valid), 32'd0);
      q_addr.push_back(exp_next);
    end
  endtask

  initial begin
    bit ok;
    imem_if.ack = 1'b0;
    imem_if.data = '0;
    @(negedge clk);
    do_reset();

    // Straight-line program ending in HALT opcode.
    fetch(16'h1000, 0); issue(0, 0, 0, 0, 0, 8'd1);
    fetch(16'h2000, 0); issue(0, 0, 0, 0, 0, 8'd2);
    fetch(16'hF000, 0); issue(0, 0, 0, 0, 0, 8'd0);
    for (int i = 0; i < 4; i++) begin
      imem_if.ack = 1'b1;
      branch = 1'b1;
      zero = 1'b1;
      @(negedge clk);
      chk("hold_req",    32'(imem_if.req), 32'd0);
      chk("hold_halted", 32'(halted),      32'd1);
      chk("hold_pc",     32'(pc),          32'd2);
      chk("hold_instr",  32'(instr),       32'hF000);
    end
    imem_if.ack = 1'b0;
    branch = 1'b0;
    zero = 1'b0;

    // Branches, delayed ACK, stall and wrap-around.
    do_reset();
    for (int a = 0; a < 5; a++) begin
      fetch(16'h1000 | 16'(a), 0);
      issue(0, 0, 0, 0, 0, 8'(a + 1));
    end
    fetch(16'h303C, 0); issue(0, 1, 1, 0, 0, 8'd2);
    fetch(16'h1002, 4); issue(3, 1, 0, 0, 1, 8'd3);
    fetch(16'h1003, 0); issue(0, 0, 0, 0, 0, 8'd4);
    fetch(16'h1004, 1); issue(0, 0, 0, 0, 0, 8'd5);
    fetch(16'h303C, 0); issue(0, 1, 0, 0, 0, 8'd6);
    fetch(16'h3020, 0); issue(0, 1, 1, 0, 0, 8'd231);
    fetch(16'h3016, 0); issue(0, 1, 1, 0, 0, 8'd254);
    fetch(16'h1000, 0); issue(0, 0, 0, 0, 0, 8'd255);
    fetch(16'h1000, 0); issue(0, 0, 0, 0, 0, 8'd0);
    fetch(16'h303D, 0); issue(0, 1, 1, 0, 0, 8'd254);
    fetch(16'h3003, 0); issue(0, 1, 1, 0, 0, 8'd2);
    fetch(16'h1234, 0); issue(0, 1, 1, 1, 0, 8'd0);

    // Reset mid-FETCH and mid-ISSUE.
    do_reset();
    wait_req(ok);
    do_reset();
    fetch(16'h2222, 2);
    do_reset();
    fetch(16'hF000, 0); issue(0, 0, 0, 0, 0, 8'd0);

    chk("issue_q_drained", 32'(q_issue.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
